// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : game_state_ctrl
// Brief    : IDLE/PLAYING/OVER game FSM with lives counter and elapsed-seconds
//            timer. Optional round time limit when GAME_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module game_state_ctrl #(
    parameter int LIVES         = 3,
    parameter int LIVES_W       = 2,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int TIME_W        = 8,
    parameter int TIME_LIMIT    = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn_i,
    input  logic               hit_i,
    output logic               game_status_o,
    output logic [LIVES_W-1:0] lives_o,
    output logic [TIME_W-1:0]  elapsed_s_o,
    output logic               game_over_o
);

    localparam int                PS_W         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PS_W-1:0]   c_PS_LAST    = PS_W'(TICKS_PER_SEC - 1);
    localparam logic [TIME_W-1:0] c_TIME_MAX   = '1;
    localparam logic [TIME_W-1:0] c_TIME_LIMIT = TIME_W'(TIME_LIMIT);
    localparam logic [LIVES_W-1:0] c_LIVES     = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] c_ONE_LIFE  = LIVES_W'(1);
`ifdef GAME_TIMEOUT_EN
    localparam bit c_TIMEOUT_EN = 1'b1;
`else
    localparam bit c_TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAYING = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t              state_q;
    logic                start_q;
    logic [PS_W-1:0]     prescaler_q;
    logic [LIVES_W-1:0]  lives_q;
    logic [TIME_W-1:0]   elapsed_q;
    logic                game_status_q;
    logic                game_over_q;

    logic                w_rise;
    logic                w_wrap;
    logic                w_timeout;
    logic                w_last_hit;
    logic [PS_W-1:0]     prescaler_d;
    logic [TIME_W-1:0]   elapsed_d;

    always_comb begin
        w_rise      = start_btn_i & ~start_q;
        w_wrap      = (prescaler_q == c_PS_LAST);
        prescaler_d = w_wrap ? '0 : prescaler_q + PS_W'(1);
        elapsed_d   = (w_wrap && (elapsed_q != c_TIME_MAX)) ? elapsed_q + TIME_W'(1) : elapsed_q;
        // Only the wrap that actually steps the counter onto the limit ends the round.
        w_timeout   = c_TIMEOUT_EN && (elapsed_d != elapsed_q) && (elapsed_d == c_TIME_LIMIT);
        w_last_hit  = hit_i && (lives_q <= c_ONE_LIFE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            prescaler_q   <= '0;
            lives_q       <= c_LIVES;
            elapsed_q     <= '0;
            game_status_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            start_q     <= start_btn_i;
            game_over_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    if (w_rise) begin
                        state_q       <= S_PLAYING;
                        game_status_q <= 1'b1;
                        lives_q       <= c_LIVES;
                        elapsed_q     <= '0;
                        prescaler_q   <= '0;
                    end
                end
                S_PLAYING: begin
                    prescaler_q <= prescaler_d;
                    elapsed_q   <= elapsed_d;
                    if (hit_i) begin
                        lives_q <= w_last_hit ? '0 : lives_q - c_ONE_LIFE;
                    end
                    if (w_last_hit || w_timeout) begin
                        state_q       <= S_OVER;
                        game_status_q <= 1'b0;
                        game_over_q   <= 1'b1;
                        prescaler_q   <= '0;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    game_status_q <= 1'b0;
                    prescaler_q   <= '0;
                end
            endcase
        end
    end

    assign game_status_o = game_status_q;
    assign lives_o       = lives_q;
    assign elapsed_s_o   = elapsed_q;
    assign game_over_o   = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_state_ctrl
// Brief    : Scoreboard bench for game_state_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_state_ctrl;

    localparam int LIVES      = 3;
    localparam int LIVES_W    = 2;
    localparam int TPS        = 10;
    localparam int TIME_W     = 4;
    localparam int TIME_LIMIT = 5;
    localparam int MAX_T      = (1 << TIME_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_btn = 1'b0;
    logic               hit = 1'b0;
    logic               game_status;
    logic [LIVES_W-1:0] lives;
    logic [TIME_W-1:0]  elapsed_s;
    logic               game_over;

    game_state_ctrl #(
        .LIVES        (LIVES),
        .LIVES_W      (LIVES_W),
        .TICKS_PER_SEC(TPS),
        .TIME_W       (TIME_W),
        .TIME_LIMIT   (TIME_LIMIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start_btn_i  (start_btn),
        .hit_i        (hit),
        .game_status_o(game_status),
        .lives_o      (lives),
        .elapsed_s_o  (elapsed_s),
        .game_over_o  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        int status;
        int lives;
        int elapsed;
        int go;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: game progress expressed as cycles played since start.
    bit m_play;
    bit m_prev;
    bit m_go;
    int m_lives;
    int m_cyc;
    int m_el;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_play  = 1'b0;
        m_prev  = 1'b0;
        m_go    = 1'b0;
        m_lives = LIVES;
        m_cyc   = 0;
        m_el    = 0;
    endfunction

    function automatic void model_step(input bit s, input bit h);
        bit rise;
        bit ended;
        rise   = s && !m_prev;
        m_prev = s;
        m_go   = 1'b0;
        ended  = 1'b0;
        if (!m_play) begin
            if (rise) begin
                m_play  = 1'b1;
                m_lives = LIVES;
                m_cyc   = 0;
                m_el    = 0;
            end
        end else begin
            if (h) begin
                if (m_lives > 1) m_lives--;
                else begin
                    m_lives = 0;
                    ended   = 1'b1;
                end
            end
            m_cyc++;
            m_el = (m_cyc / TPS > MAX_T) ? MAX_T : m_cyc / TPS;
`ifdef GAME_TIMEOUT_EN
            if (m_cyc == TIME_LIMIT * TPS) ended = 1'b1;
`endif
            if (ended) begin
                m_play = 1'b0;
                m_go   = 1'b1;
            end
        end
    endfunction

    task automatic step(input bit s, input bit h);
        exp_t e;
        start_btn = s;
        hit       = h;
        model_step(s, h);
        e.status  = m_play;
        e.lives   = m_lives;
        e.elapsed = m_el;
        e.go      = m_go;
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start_btn = 1'b0;
        hit       = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_status", int'(game_status), 0);
        chk("rst_lives", int'(lives), LIVES);
        chk("rst_elapsed", int'(elapsed_s), 0);
        chk("rst_game_over", int'(game_over), 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: one output set per clock, compared mid-cycle.
    initial begin : p_monitor
        exp_t e;
        bit   prev_go;
        prev_go = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("game_status", int'(game_status), e.status);
                chk("lives", int'(lives), e.lives);
                chk("elapsed_s", int'(elapsed_s), e.elapsed);
                chk("game_over", int'(game_over), e.go);
                if (prev_go) chk("game_over_consecutive", int'(game_over), 0);
            end
            prev_go = game_over;
        end
    end

    initial begin : p_stim
        bit s;
        model_reset();
        do_reset();
        repeat (5) step(1'b0, 1'b0);

        // Start, then play 30 cycles with the button held.
        step(1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b0);

        // Three hits to game over, then a fourth ignored hit.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
        end

        // Held start in OVER restarts exactly once.
        step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);

        // Back to OVER, then hit and rise together.
        repeat (3) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);

        // Long play without hits: timeout or saturation of elapsed_s.
        repeat (175) step(1'b1, 1'b0);

        // Reset while playing on the last life.
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        do_reset();
        repeat (3) step(1'b0, 1'b0);

        // Randomized play.
        s = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 11) == 0) s = ~s;
            step(s, ($urandom_range(0, 14) == 0));
            if (i == 1000) do_reset();
        end
        start_btn = 1'b0;
        hit       = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
